apb_slave_mem_responder: RTL and testbench
==========================================

Name: apb_slave_mem_responder

Overview:
Synthesizable APB slave that sits directly downstream of the APB master driver/interface and consumes its transfers. It serves a word-organised memory, inserts a programmable number of wait states and applies PSTRB byte-lane writes. It flags PSLVERR for out-of-range or misaligned addresses. One instance per PSELx bit; it serves as the DUT-side responder for the slave agent to monitor.

Parameters:
ADDRESS_WIDTH, 32, PADDR width.
DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8, max 32.
MEM_DEPTH, 64, number of DATA_WIDTH words.
MIN_ADDRESS, 0, byte address of word 0; slave range is MIN_ADDRESS .. MIN_ADDRESS + MEM_DEPTH*(DATA_WIDTH/8) - 1.

Ports:
pclk  input  1  clock; all logic on rising edge.
preset_n  input  1  reset, synchronous, active-low.
psel  input  1  this slave's PSELx bit.
penable  input  1  access phase.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDRESS_WIDTH  byte address.
pwdata  input  DATA_WIDTH  write data.
pstrb  input  DATA_WIDTH/8  write byte strobes.
pprot  input  3  protection; accepted, not checked.
cfg_wait_states  input  4  wait states per transfer (0-15), sampled in setup cycle.
prdata  output  DATA_WIDTH  read data, valid when pready=1 and pwrite=0.
pready  output  1  transfer complete.
pslverr  output  1  error response, valid only with pready=1.
err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (preset_n=0 at an edge): state=IDLE; pready=0, pslverr=0, prdata=0, err_count=0; all memory words cleared to 0. Reset mid-transfer abandons it with no write.
- All outputs registered.
- FSM states:
  - IDLE: on psel=1 & penable=0 (setup), capture paddr/pwrite/pwdata/pstrb and wait_cnt=cfg_wait_states. Go to RESP if cfg_wait_states==0, else WAIT. psel=1 & penable=1 without setup is ignored; stay IDLE.
  - WAIT: if psel=0, go to IDLE (aborted, no write, no error count). Otherwise wait_cnt decrements; on the edge where wait_cnt==1, go to RESP.
  - RESP: pready=1 for exactly one cycle; go to IDLE at next edge.
- Latency: setup at cycle T0 gives pready=1 in cycle T1+N, N=cfg_wait_states; zero-wait transfer is 2 cycles.
- pready=0 in IDLE and WAIT.
- Back-to-back: new setup immediately after RESP is accepted in IDLE with no gap cycle.
- Error when captured paddr < MIN_ADDRESS, > range top, or paddr[1:0]!=0 (for DATA_WIDTH=32).
  - With error: pslverr=1 with pready, no memory write, prdata=0, err_count increments (saturates at 255).
- Word index = (paddr - MIN_ADDRESS) >> log2(DATA_WIDTH/8).
- Write (no error): memory updated on the edge leaving RESP; only lanes with pstrb[i]=1 written (byte i = bits 8i+7:8i). pstrb=0 is legal: no change, no error.
- Read (no error): prdata loaded with mem[index] on the edge entering RESP; held until the next read response or reset. pstrb ignored on reads.
- Address/data/control are sampled only in setup. Changes during WAIT are ignored; the protocol checker, not this block, flags them.
- pslverr is cleared to 0 whenever pready=0.

Test Plan:
- Reset then read 0x0000_0010, wait=0 -> pready high in cycle 2, prdata=0x0000_0000, pslverr=0.
- Write 0x0000_0008 data 0xDEADBEEF pstrb=4'b1111 wait=3, then read it back -> write pready in cycle 5; readback 0xDEADBEEF.
- Write 0x0000_0008 data 0x11223344 pstrb=4'b0101 over 0xDEADBEEF -> readback 0xDE22BE44.
- Read 0x0000_0100 (MEM_DEPTH=64, top=0xFF) and read 0x0000_0006 -> both pslverr=1, prdata=0, err_count=2; memory unchanged.
- Write with wait=5, psel dropped after 2 access cycles -> pready never asserted, target word unchanged, FSM IDLE; next transfer completes normally.
- 256 error transfers -> err_count=255 (saturated); preset_n=0 for one edge -> err_count=0, pready=0, all words read 0.

Source files
------------

// File: rtl/apb_slave_mem_responder_if.sv
// apb_slave_mem_responder_if: APB bus signals between one master and one slave select
interface apb_slave_mem_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0] pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input prdata, pready, pslverr
  );
  modport slave (
    input psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem_responder.sv
// apb_slave_mem_responder: APB slave over a word memory with wait states, byte strobes and range/alignment errors
module apb_slave_mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int MIN_ADDRESS = 0
) (
  input logic pclk,
  input logic preset_n,
  apb_slave_mem_responder_if.slave bus,
  input logic [3:0] cfg_wait_states,
  output logic [7:0] err_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] LO = (ADDRESS_WIDTH + 1)'(MIN_ADDRESS);
  localparam logic [ADDRESS_WIDTH:0] SPAN = (ADDRESS_WIDTH + 1)'(MEM_DEPTH * BYTES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0] strb_q;
  logic [3:0] wait_cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH:0] offset;
  logic [ADDRESS_WIDTH:0] word;
  logic [IW-1:0] idx;
  logic wr;
  logic err;
  logic setup;
  logic resp_go;
  logic unused_bits;
  // In IDLE the response may be produced straight from the setup-phase bus; later from the captured copy.
  // A borrow below MIN_ADDRESS wraps offset far above SPAN, so one compare covers both range ends.
  assign addr = state == IDLE ? bus.paddr : addr_q;
  assign wr = state == IDLE ? bus.pwrite : write_q;
  assign offset = {1'b0, addr} - LO;
  assign word = offset / (ADDRESS_WIDTH + 1)'(BYTES);
  assign idx = word[IW-1:0];
  assign err = offset >= SPAN || (addr % (ADDRESS_WIDTH)'(BYTES)) != '0;
  assign setup = state == IDLE && bus.psel && !bus.penable;
  assign resp_go = (setup && cfg_wait_states == 4'd0) || (state == WAIT && bus.psel && wait_cnt == 4'd1);
  assign unused_bits = ^{bus.pprot, word[ADDRESS_WIDTH:IW]};
  // Transfer FSM with registered responses, error counting and strobed memory writes
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= IDLE;
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata <= '0;
      err_count <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      wait_cnt <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.pready <= resp_go;
      bus.pslverr <= resp_go && err;
      if (resp_go && err) bus.prdata <= '0;
      else if (resp_go && !wr) bus.prdata <= mem[idx];
      if (resp_go && err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        IDLE: if (setup) begin
          addr_q <= bus.paddr;
          write_q <= bus.pwrite;
          wdata_q <= bus.pwdata;
          strb_q <= bus.pstrb;
          wait_cnt <= cfg_wait_states;
          state <= cfg_wait_states == 4'd0 ? RESP : WAIT;
        end
        WAIT: begin
          state <= !bus.psel ? IDLE : wait_cnt == 4'd1 ? RESP : WAIT;
          wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          if (write_q && !err)
            for (int i = 0; i < BYTES; i++)
              if (strb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// tb_apb_slave_mem_responder: directed checks of latency, strobes, errors, abort and reset
module tb_apb_slave_mem_responder;
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic [3:0] cfg = 4'd0;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;
  apb_slave_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb_slave_mem_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .MIN_ADDRESS(0)
  ) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .bus(bus),
    .cfg_wait_states(cfg),
    .err_count(err_count)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] ws, output logic [31:0] rd, output logic er, output int cyc);
    @(posedge pclk); #1;
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = w;
    bus.paddr = a;
    bus.pwdata = d;
    bus.pstrb = s;
    cfg = ws;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    cyc = 1;
    while (!bus.pready && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
    end
    rd = bus.prdata;
    er = bus.pslverr;
  endtask
  task automatic wr(input string t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [3:0] ws, input logic ee);
    logic [31:0] unused_rd;
    logic er;
    int cyc;
    xfer(1'b1, a, d, s, ws, unused_rd, er, cyc);
    chk({t, " latency"}, cyc, 32'(ws) + 1);
    chk({t, " pslverr"}, {31'd0, er}, {31'd0, ee});
  endtask
  task automatic rd(input string t, input logic [31:0] a, input logic [3:0] ws,
                    input logic [31:0] ed, input logic ee);
    logic [31:0] d;
    logic er;
    int cyc;
    xfer(1'b0, a, 32'h0, 4'hF, ws, d, er, cyc);
    chk({t, " latency"}, cyc, 32'(ws) + 1);
    chk({t, " prdata"}, d, ed);
    chk({t, " pslverr"}, {31'd0, er}, {31'd0, ee});
  endtask
  task automatic pulse_reset();
    @(posedge pclk); #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    preset_n = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bit saw_ready;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite = 1'b0;
    bus.paddr = '0;
    bus.pwdata = '0;
    bus.pstrb = '0;
    bus.pprot = 3'b010;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 1'b1;
    chk("reset pready", {31'd0, bus.pready}, 32'd0);
    chk("reset pslverr", {31'd0, bus.pslverr}, 32'd0);
    chk("reset prdata", bus.prdata, 32'h0);
    chk("reset err_count", {24'd0, err_count}, 32'd0);
    rd("read 0x10 w0", 32'h10, 4'd0, 32'h0, 1'b0);
    @(posedge pclk); #1;
    chk("pready single cycle", {31'd0, bus.pready}, 32'd0);
    wr("write 0x08 full w3", 32'h08, 32'hDEADBEEF, 4'b1111, 4'd3, 1'b0);
    rd("readback 0x08", 32'h08, 4'd1, 32'hDEADBEEF, 1'b0);
    wr("write 0x08 strb 0101", 32'h08, 32'h11223344, 4'b0101, 4'd2, 1'b0);
    rd("readback strobed", 32'h08, 4'd0, 32'hDE22BE44, 1'b0);
    wr("write strb 0", 32'h08, 32'hFFFFFFFF, 4'b0000, 4'd0, 1'b0);
    rd("readback strb 0", 32'h08, 4'd0, 32'hDE22BE44, 1'b0);
    wr("write top word", 32'hFC, 32'hA5A50001, 4'b1111, 4'd1, 1'b0);
    rd("read top word", 32'hFC, 4'd0, 32'hA5A50001, 1'b0);
    rd("read word 0", 32'h00, 4'd0, 32'h0, 1'b0);
    rd("read 0x100 range", 32'h100, 4'd0, 32'h0, 1'b1);
    chk("err_count 1", {24'd0, err_count}, 32'd1);
    rd("read 0x06 misaligned", 32'h06, 4'd2, 32'h0, 1'b1);
    chk("err_count 2", {24'd0, err_count}, 32'd2);
    wr("write 0x0A misaligned", 32'h0A, 32'h0, 4'b1111, 4'd0, 1'b1);
    chk("err_count 3", {24'd0, err_count}, 32'd3);
    rd("mem unchanged after errors", 32'h08, 4'd0, 32'hDE22BE44, 1'b0);
    @(posedge pclk); #1;
    bus.psel = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite = 1'b1;
    bus.paddr = 32'h08;
    bus.pwdata = 32'h0;
    bus.pstrb = 4'b1111;
    cfg = 4'd5;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    chk("abort access 1 pready", {31'd0, bus.pready}, 32'd0);
    @(posedge pclk); #1;
    chk("abort access 2 pready", {31'd0, bus.pready}, 32'd0);
    @(posedge pclk); #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    saw_ready = 1'b0;
    repeat (8) begin
      @(posedge pclk); #1;
      if (bus.pready) saw_ready = 1'b1;
    end
    chk("abort no pready", {31'd0, saw_ready}, 32'd0);
    rd("read after abort", 32'h08, 4'd1, 32'hDE22BE44, 1'b0);
    for (int k = 0; k < 256; k++) begin
      logic [31:0] d;
      logic er;
      int cyc;
      xfer(1'b0, 32'h100, 32'h0, 4'hF, 4'd0, d, er, cyc);
    end
    chk("err_count saturated", {24'd0, err_count}, 32'd255);
    pulse_reset();
    chk("post reset pready", {31'd0, bus.pready}, 32'd0);
    chk("post reset pslverr", {31'd0, bus.pslverr}, 32'd0);
    chk("post reset err_count", {24'd0, err_count}, 32'd0);
    chk("post reset prdata", bus.prdata, 32'h0);
    rd("post reset 0x08", 32'h08, 4'd0, 32'h0, 1'b0);
    rd("post reset 0xFC", 32'hFC, 4'd0, 32'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
